easyaxi_slv_rd_ctrl: RTL and testbench
======================================

Name: easyaxi_slv_rd_ctrl

Overview:
AXI slave read responder, the far end of the master read controller. It accepts AR requests into an in-order outstanding queue and generates R bursts for each request in turn. Each beat carries a deterministic, address-derived data pattern, so a master-side bench can self-check. It supports FIXED, INCR and WRAP bursts with backpressure on both channels.

Parameters:
OST_DEPTH, 4, outstanding AR queue depth (power of 2, >=2)
ERR_ADDR_BASE, 32'h0000_1000, requests with araddr >= this value are answered SLVERR on every beat

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axi_slv_arvalid  in  1  AR valid
axi_slv_arready  out  1  AR ready
axi_slv_arid  in  AXI_ID_W  AR id
axi_slv_araddr  in  AXI_ADDR_W  start address
axi_slv_arlen  in  AXI_LEN_W  beats-1
axi_slv_arsize  in  AXI_SIZE_W  log2 bytes/beat
axi_slv_arburst  in  AXI_BURST_W  FIXED/INCR/WRAP
axi_slv_aruser  in  AXI_USER_W  user sideband
axi_slv_rvalid  out  1  R valid
axi_slv_rready  in  1  R ready
axi_slv_rid  out  AXI_ID_W  id of the head request
axi_slv_rdata  out  AXI_DATA_W  beat data
axi_slv_rresp  out  AXI_RESP_W  OKAY/SLVERR
axi_slv_rlast  out  1  final beat
axi_slv_ruser  out  AXI_USER_W  aruser echoed

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset empties the queue and clears all state. rvalid, rlast, rdata, rid, rresp and ruser reset to 0.
- arready = ~full, where full is taken from the registered count. It is 1 after reset release.
- When the queue is full, no push is accepted, even if a pop occurs in the same cycle.
- AR handshake (arvalid & arready) pushes {id, addr, len, size, burst, user, err} into a circular queue with wr_ptr/rd_ptr and a count. err = (araddr >= ERR_ADDR_BASE), or WRAP with len not in {1,3,7,15}.
- Push and pop in the same cycle leave the count unchanged.
- R engine, 2 states:
  - IDLE: if not empty, load beat_addr = head.addr and beat_cnt = 0, then go to SEND (registered; rvalid rises 1 cycle after load).
  - SEND: hold rvalid=1. rid and ruser come from the head entry. rdata = beat_addr zero-extended to AXI_DATA_W. rresp = SLVERR if err, otherwise OKAY. rlast = (beat_cnt == head.len).
  - On rready & ~rlast: beat_cnt+1 and beat_addr = next_addr.
  - On rready & rlast: pop the head. If the queue still holds an entry (not counting a same-cycle push), reload from the new head and stay in SEND, so the next burst starts the following cycle. Otherwise go to IDLE.
- Minimum latency: AR handshake at cycle N gives first rvalid at N+2 from an empty queue (N+1 queue visible, N+2 data registered).
- All R outputs stay stable while rvalid & ~rready (AXI rule).
- Responses are strictly in AR acceptance order, with no ID reordering.
- Address math, with bytes = 1<<size and mask = bytes*(len+1)-1:
  - FIXED: next = beat_addr.
  - INCR: next = (beat_addr & ~(bytes-1)) + bytes, wrapping modulo 2^AXI_ADDR_W.
  - WRAP: next = (beat_addr & ~mask) | ((beat_addr + bytes) & mask).
- Illegal WRAP len: the burst still returns len+1 beats with SLVERR, and addressing falls back to INCR.
- Reset mid-burst: rvalid drops asynchronously and the burst is abandoned with no resume.
- arlen is limited to 15 (beat_cnt is 4 bits); a larger arlen is truncated to its low 4 bits. This is documented, not checked.

Decomposition:
- Shared define header (existing easyaxi define file) supplies AXI_*_W widths, AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/SLVERR/DECERR and AXI_SIZE_* encodings. No new constants are needed beyond ERR_ADDR_BASE.
- One sub-module, easyaxi_burst_addr: purely combinational next-beat address from (addr, len, size, burst) plus a wrap-legal flag. It is reusable by a future write-side slave.

Test Plan:
- INCR addr 0x10, len 3, size 4B, rready=1 -> rdata 0x10, 0x14, 0x18, 0x1C; rlast only on the 4th beat; rresp OKAY; rid matches arid.
- WRAP addr 0x34, len 3, size 4B -> rdata 0x34, 0x38, 0x3C, 0x30. FIXED addr 0x40, len 3 -> rdata 0x40 four times.
- rready=0 with 5 back-to-back ARs (ids 0..4), OST_DEPTH=4:
  - arready falls after the 4th handshake.
  - When rready rises, bursts return in id order 0, 1, 2, 3, and AR id 4 is accepted after the first pop.
  - Bursts are back-to-back with no idle cycle.
- Random rready toggling on INCR addr 0x0, len 7 -> rvalid never drops mid-burst; rdata/rlast stay stable while stalled; 8 beats 0x0..0x1C.
- araddr 0x1000, len 1 -> both beats rresp SLVERR. WRAP with len 2 -> SLVERR, INCR addresses.
- rst_n asserted on beat 2 of a len 7 burst -> rvalid=0 immediately. After release arready=1, rvalid stays 0 and a new AR is served normally.

Source files
------------

// File: rtl/easyaxi_slv_rd_ctrl_pkg.sv
// Shared AXI widths, encodings and the outstanding-queue entry
// used by the easyaxi read-slave slice.
package easyaxi_slv_rd_ctrl_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;
    localparam int AXI_USER_W  = 4;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
    localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
    localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B = 3'd2;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } r_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [AXI_USER_W-1:0]  user;
        logic                   err;
    } ost_ent_t;

    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/easyaxi_slv_rd_ctrl_if.sv
// AR/R channel bundle between a read master and the read slave.
// Signal names match the existing easyaxi slave port names.
interface easyaxi_slv_rd_ctrl_if;
    import easyaxi_slv_rd_ctrl_pkg::*;

    logic                   axi_slv_arvalid;
    logic                   axi_slv_arready;
    logic [AXI_ID_W-1:0]    axi_slv_arid;
    logic [AXI_ADDR_W-1:0]  axi_slv_araddr;
    logic [AXI_LEN_W-1:0]   axi_slv_arlen;
    logic [AXI_SIZE_W-1:0]  axi_slv_arsize;
    logic [AXI_BURST_W-1:0] axi_slv_arburst;
    logic [AXI_USER_W-1:0]  axi_slv_aruser;
    logic                   axi_slv_rvalid;
    logic                   axi_slv_rready;
    logic [AXI_ID_W-1:0]    axi_slv_rid;
    logic [AXI_DATA_W-1:0]  axi_slv_rdata;
    logic [AXI_RESP_W-1:0]  axi_slv_rresp;
    logic                   axi_slv_rlast;
    logic [AXI_USER_W-1:0]  axi_slv_ruser;

    modport master (
        output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr,
        output axi_slv_arlen, axi_slv_arsize, axi_slv_arburst,
        output axi_slv_aruser, axi_slv_rready,
        input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid,
        input  axi_slv_rdata, axi_slv_rresp, axi_slv_rlast,
        input  axi_slv_ruser
    );

    modport slave (
        input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr,
        input  axi_slv_arlen, axi_slv_arsize, axi_slv_arburst,
        input  axi_slv_aruser, axi_slv_rready,
        output axi_slv_arready, axi_slv_rvalid, axi_slv_rid,
        output axi_slv_rdata, axi_slv_rresp, axi_slv_rlast,
        output axi_slv_ruser
    );

endinterface

// File: rtl/easyaxi_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus a WRAP-length
// legality flag; shared by read and write side slaves.
module easyaxi_burst_addr
    import easyaxi_slv_rd_ctrl_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0]  addr,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [AXI_ADDR_W-1:0]  next_addr,
    output logic                   wrap_ok
);

    logic [AXI_ADDR_W-1:0] bytes;
    logic [AXI_ADDR_W-1:0] mask;
    logic [AXI_ADDR_W-1:0] incr_addr;

    always_comb begin
        bytes     = AXI_ADDR_W'(1) << size;
        mask      = bytes * (AXI_ADDR_W'(len) + AXI_ADDR_W'(1))
                    - AXI_ADDR_W'(1);
        wrap_ok   = wrap_len_ok(len);
        incr_addr = (addr & ~(bytes - AXI_ADDR_W'(1))) + bytes;
        next_addr = incr_addr;
        // Illegal WRAP lengths and the reserved encoding walk as INCR.
        unique case (1'b1)
            (burst == AXI_BURST_FIXED): next_addr = addr;
            (burst == AXI_BURST_WRAP) && wrap_ok:
                next_addr = (addr & ~mask) | ((addr + bytes) & mask);
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/easyaxi_slv_rd_ctrl.sv
// AXI read slave: in-order AR queue feeding an R burst engine whose
// beat data is the beat address, so a master bench can self-check.
module easyaxi_slv_rd_ctrl
    import easyaxi_slv_rd_ctrl_pkg::*;
#(
    parameter int                    OST_DEPTH     = 4,
    parameter logic [AXI_ADDR_W-1:0] ERR_ADDR_BASE = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    easyaxi_slv_rd_ctrl_if.slave  axi
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ost_ent_t              mem [OST_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    ost_ent_t              ar_ent;
    ost_ent_t              head;
    ost_ent_t              nxt_head;

    r_state_e              state_q;
    r_state_e              state_d;
    logic [AXI_ADDR_W-1:0] beat_addr_q;
    logic [3:0]            beat_cnt_q;
    logic                  load;
    logic                  adv;
    ost_ent_t              load_ent;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic                  wrap_ok;
    logic                  send;
    logic                  last;
    logic                  resp_err;

    assign full  = (cnt_q == CNT_W'(OST_DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = axi.axi_slv_arvalid & ~full;
    assign send  = (state_q == R_SEND);
    assign last  = (beat_cnt_q == head.len[3:0]);
    assign pop   = send & axi.axi_slv_rready & last;

    assign head     = mem[rd_ptr_q];
    assign nxt_head = mem[rd_ptr_q + PTR_W'(1)];

    always_comb begin
        ar_ent       = '0;
        ar_ent.id    = axi.axi_slv_arid;
        ar_ent.addr  = axi.axi_slv_araddr;
        ar_ent.len   = axi.axi_slv_arlen;
        ar_ent.size  = axi.axi_slv_arsize;
        ar_ent.burst = axi.axi_slv_arburst;
        ar_ent.user  = axi.axi_slv_aruser;
        ar_ent.err   = (axi.axi_slv_araddr >= ERR_ADDR_BASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OST_DEPTH; i++) mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= ar_ent;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    easyaxi_burst_addr u_burst_addr (
        .addr      (beat_addr_q),
        .len       (head.len),
        .size      (head.size),
        .burst     (head.burst),
        .next_addr (next_addr),
        .wrap_ok   (wrap_ok)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        adv      = 1'b0;
        load_ent = head;
        unique case (state_q)
            R_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = R_SEND;
                end
            end
            R_SEND: begin
                if (axi.axi_slv_rready && !last) begin
                    adv = 1'b1;
                end else if (axi.axi_slv_rready) begin
                    // A push in this same cycle is not yet in cnt_q.
                    if (cnt_q > CNT_W'(1)) begin
                        load     = 1'b1;
                        load_ent = nxt_head;
                    end else begin
                        state_d = R_IDLE;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= R_IDLE;
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                beat_addr_q <= load_ent.addr;
                beat_cnt_q  <= '0;
            end else if (adv) begin
                beat_addr_q <= next_addr;
                beat_cnt_q  <= beat_cnt_q + 4'd1;
            end
        end
    end

    assign resp_err = head.err |
                      ((head.burst == AXI_BURST_WRAP) & ~wrap_ok);

    assign axi.axi_slv_arready = ~full;
    assign axi.axi_slv_rvalid  = send;
    assign axi.axi_slv_rlast   = send & last;
    assign axi.axi_slv_rid     = send ? head.id : '0;
    assign axi.axi_slv_ruser   = send ? head.user : '0;
    assign axi.axi_slv_rdata   = send ? AXI_DATA_W'(beat_addr_q) : '0;
    assign axi.axi_slv_rresp   = !send   ? AXI_RESP_OKAY :
                                 resp_err ? AXI_RESP_SLVERR :
                                            AXI_RESP_OKAY;

endmodule

// File: tb/tb_easyaxi_slv_rd_ctrl.sv
// Randomized bench for the AXI read slave against a burst-level
// model of the expected R beats.
module tb_easyaxi_slv_rd_ctrl;
    import easyaxi_slv_rd_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    easyaxi_slv_rd_ctrl_if axi();

    easyaxi_slv_rd_ctrl #(
        .OST_DEPTH     (4),
        .ERR_ADDR_BASE (32'h0000_1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  user;
    } beat_t;

    beat_t exp_q[$];
    int    outstanding = 0;
    int    pops = 0;
    int    rhs = 0;
    int    rmode = 0;

    function automatic logic [31:0] model_addr(
        input logic [31:0] a, input int len, input int size,
        input logic [1:0] burst, input int i);
        longint bytes = longint'(1) << size;
        longint total = bytes * (len + 1);
        longint lo;
        bit wrap_legal = (len == 1 || len == 3 || len == 7 || len == 15);
        if (burst == AXI_BURST_FIXED) return a;
        if (burst == AXI_BURST_WRAP && wrap_legal) begin
            lo = (longint'(a) / total) * total;
            return 32'(lo + ((longint'(a) - lo + i * bytes) % total));
        end
        if (i == 0) return a;
        return 32'((longint'(a) / bytes) * bytes + i * bytes);
    endfunction

    task automatic model_push(input logic [3:0] id, input logic [31:0] a,
        input logic [7:0] len, input logic [2:0] size,
        input logic [1:0] burst, input logic [3:0] user);
        int  n = int'(len[3:0]);
        bit  bad_wrap = (burst == AXI_BURST_WRAP) &&
                        !(n == 1 || n == 3 || n == 7 || n == 15);
        bit  err = (a >= 32'h1000) || bad_wrap;
        beat_t b;
        for (int i = 0; i <= n; i++) begin
            b.id   = id;
            b.data = model_addr(a, n, int'(size), burst, i);
            b.resp = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            b.last = (i == n);
            b.user = user;
            exp_q.push_back(b);
        end
    endtask

    logic [42:0] held;
    bit stalled = 0, mid = 0, exp_b2b = 0, exp_gap = 0;

    always @(negedge clk) begin
        beat_t e;
        int rem;
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            stalled = 0; mid = 0; exp_b2b = 0; exp_gap = 0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(axi.axi_slv_rvalid), 64'd1);
                chk("stall_hold", 64'({axi.axi_slv_rid, axi.axi_slv_rdata,
                    axi.axi_slv_rresp, axi.axi_slv_rlast,
                    axi.axi_slv_ruser}), 64'(held));
            end
            if (mid) chk("mid_valid", 64'(axi.axi_slv_rvalid), 64'd1);
            if (exp_b2b) chk("b2b", 64'(axi.axi_slv_rvalid), 64'd1);
            if (exp_gap) chk("gap", 64'(axi.axi_slv_rvalid), 64'd0);
            stalled = 0; mid = 0; exp_b2b = 0; exp_gap = 0;
            rem = outstanding - 1;
            if (axi.axi_slv_rvalid && axi.axi_slv_rready) begin
                rhs++;
                if (exp_q.size() == 0) begin
                    chk("r_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rid", 64'(axi.axi_slv_rid), 64'(e.id));
                    chk("rdata", 64'(axi.axi_slv_rdata), 64'(e.data));
                    chk("rresp", 64'(axi.axi_slv_rresp), 64'(e.resp));
                    chk("rlast", 64'(axi.axi_slv_rlast), 64'(e.last));
                    chk("ruser", 64'(axi.axi_slv_ruser), 64'(e.user));
                end
                if (axi.axi_slv_rlast) begin
                    pops++;
                    outstanding--;
                    if (rem > 0) exp_b2b = 1;
                    else exp_gap = 1;
                end else begin
                    mid = 1;
                end
            end else if (axi.axi_slv_rvalid) begin
                stalled = 1;
                held = {axi.axi_slv_rid, axi.axi_slv_rdata,
                        axi.axi_slv_rresp, axi.axi_slv_rlast,
                        axi.axi_slv_ruser};
            end
            if (axi.axi_slv_arvalid && axi.axi_slv_arready) begin
                model_push(axi.axi_slv_arid, axi.axi_slv_araddr,
                           axi.axi_slv_arlen, axi.axi_slv_arsize,
                           axi.axi_slv_arburst, axi.axi_slv_aruser);
                outstanding++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        axi.axi_slv_rready = (rmode == 0) ? 1'b1 :
                             (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
        input logic [7:0] len, input logic [2:0] size,
        input logic [1:0] burst, input logic [3:0] user);
        int n = 0;
        axi.axi_slv_arvalid = 1'b1;
        axi.axi_slv_arid    = id;
        axi.axi_slv_araddr  = a;
        axi.axi_slv_arlen   = len;
        axi.axi_slv_arsize  = size;
        axi.axi_slv_arburst = burst;
        axi.axi_slv_aruser  = user;
        @(negedge clk);
        while (!axi.axi_slv_arready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!axi.axi_slv_arready) chk("ar_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 axi.axi_slv_arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((outstanding != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rvalid"}, 64'(axi.axi_slv_rvalid), 64'd0);
        chk({tag, "_rlast"}, 64'(axi.axi_slv_rlast), 64'd0);
        chk({tag, "_rdata"}, 64'(axi.axi_slv_rdata), 64'd0);
        chk({tag, "_rid"}, 64'(axi.axi_slv_rid), 64'd0);
        chk({tag, "_rresp"}, 64'(axi.axi_slv_rresp), 64'd0);
        chk({tag, "_ruser"}, 64'(axi.axi_slv_ruser), 64'd0);
        chk({tag, "_arready"}, 64'(axi.axi_slv_arready), 64'd1);
    endtask

    initial begin
        int n;
        axi.axi_slv_arvalid = 1'b0;
        axi.axi_slv_arid    = '0;
        axi.axi_slv_araddr  = '0;
        axi.axi_slv_arlen   = '0;
        axi.axi_slv_arsize  = '0;
        axi.axi_slv_arburst = '0;
        axi.axi_slv_aruser  = '0;
        axi.axi_slv_rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        @(posedge clk); #1;
        send_ar(4'd5, 32'h10, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR, 4'h3);
        @(negedge clk);
        chk("lat_n1", 64'(axi.axi_slv_rvalid), 64'd0);
        @(negedge clk);
        chk("lat_n2", 64'(axi.axi_slv_rvalid), 64'd1);
        drain();
        send_ar(4'd1, 32'h34, 8'd3, AXI_SIZE_4B, AXI_BURST_WRAP, 4'h1);
        send_ar(4'd2, 32'h40, 8'd3, AXI_SIZE_4B, AXI_BURST_FIXED, 4'h2);
        drain();

        rmode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            send_ar(4'(i), 32'h100 + 32'(i * 16), 8'd1, AXI_SIZE_4B,
                    AXI_BURST_INCR, 4'(i));
        @(negedge clk);
        chk("full_arready", 64'(axi.axi_slv_arready), 64'd0);
        fork
            begin
                send_ar(4'd4, 32'h200, 8'd1, AXI_SIZE_4B,
                        AXI_BURST_INCR, 4'd4);
                chk("ar4_after_pop", 64'(pops >= 1), 64'd1);
            end
            begin
                repeat (4) @(negedge clk);
                chk("full_hold", 64'(axi.axi_slv_arready), 64'd0);
                rmode = 0;
            end
        join
        drain();

        rmode = 1;
        send_ar(4'd7, 32'h0, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 4'h7);
        drain();
        rmode = 0;
        send_ar(4'd8, 32'h1000, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR, 4'h8);
        send_ar(4'd9, 32'h24, 8'd2, AXI_SIZE_4B, AXI_BURST_WRAP, 4'h9);
        drain();

        n = rhs;
        send_ar(4'd3, 32'h300, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 4'h3);
        while (rhs < n + 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_rvalid", 64'(axi.axi_slv_rvalid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", 64'(axi.axi_slv_rvalid), 64'd0);
        @(posedge clk); #1;
        send_ar(4'd6, 32'h80, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR, 4'h6);
        drain();

        rmode = 1;
        for (int i = 0; i < 40; i++)
            send_ar(4'($urandom), 32'($urandom_range(0, 32'h17ff)),
                    8'($urandom_range(0, 15)), 3'($urandom_range(0, 2)),
                    2'($urandom_range(0, 2)), 4'($urandom));
        drain();
        rmode = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
